// File: rtl/bitstream_decoder.sv
// Decodes a unipolar stochastic bitstream by counting ones over each BITSTREAM-bit window
// and rescaling the count to a signed QUANT-bit value. Define BSDEC_SAT_EN to saturate a full window.
module bitstream_decoder #(
   parameter int BITSTREAM = 64,
   parameter int QUANT     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QUANT-1:0] out_data,
   output logic             out_sat
);

   localparam int PW    = $clog2(BITSTREAM);
   localparam int SHIFT = QUANT - PW;
   localparam logic [PW-1:0]  LAST_POS = PW'(BITSTREAM - 1);
   localparam logic [QUANT:0] HALF     = (QUANT+1)'(1) << (QUANT - 1);

   generate
      if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bs_check
         $error("bitstream_decoder: BITSTREAM must be a power of two");
      end
      if (QUANT < PW) begin : g_quant_check
         $error("bitstream_decoder: QUANT must be >= clog2(BITSTREAM)");
      end
   endgenerate

   logic [PW-1:0]    pos_q, pos_d;
   logic [PW:0]      ones_q, ones_d;
   logic             out_valid_q, out_valid_d;
   logic [QUANT-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;

   logic             accept;
   logic             complete;
   logic [PW:0]      count;
   logic [QUANT-1:0] result;

   // Stall only when this bit would complete a window whose slot is still occupied.
   assign in_ready  = !(pos_q == LAST_POS && out_valid_q && !out_ready);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

   always_comb begin
      accept      = in_valid && in_ready && !clear;
      complete    = accept && (pos_q == LAST_POS);
      count       = ones_q + (PW+1)'(in_bit);
      result      = QUANT'(((QUANT+1)'(count) << SHIFT) - HALF);
      pos_d       = pos_q;
      ones_d      = ones_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;

      if (clear) begin
         pos_d  = '0;
         ones_d = '0;
      end else if (accept) begin
         if (complete) begin
            pos_d  = '0;
            ones_d = '0;
         end else begin
            pos_d  = pos_q + PW'(1);
            ones_d = count;
         end
      end

      if (complete) begin
         out_valid_d = 1'b1;
`ifdef BSDEC_SAT_EN
         // The top count bit is set only for an all-ones window, the single out-of-range case.
         if (count[PW]) begin
            out_data_d = {1'b0, {(QUANT-1){1'b1}}};
            out_sat_d  = 1'b1;
         end else begin
            out_data_d = result;
            out_sat_d  = 1'b0;
         end
`else
         out_data_d = result;
         out_sat_d  = 1'b0;
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q       <= '0;
         ones_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         pos_q       <= pos_d;
         ones_q      <= ones_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Self-checking bench for bitstream_decoder: directed windows plus random traffic against a
// queue-based window model; honours BSDEC_SAT_EN for the all-ones expectation.
module tb_bitstream_decoder;

   localparam int BITSTREAM = 64;
   localparam int QUANT     = 8;
   localparam int SCALE     = 1 << (QUANT - $clog2(BITSTREAM));

   logic             clk = 1'b0;
   logic             rst, clear, in_valid, in_bit, out_ready;
   logic             in_ready, out_valid, out_sat;
   logic [QUANT-1:0] out_data;

   always #5 clk = ~clk;

   bitstream_decoder #(.BITSTREAM(BITSTREAM), .QUANT(QUANT)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   int checks = 0;
   int errors = 0;
   int windows = 0;

   // Model: the accepted bits of the current window, and the one-deep output slot.
   bit             win_q[$];
   bit             exp_valid;
   logic [QUANT-1:0] exp_data;
   bit             exp_sat;
   bit             win_bits[BITSTREAM];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_load(input int c);
      int v;
      v = c * SCALE - (1 << (QUANT - 1));
`ifdef BSDEC_SAT_EN
      if (v > (1 << (QUANT - 1)) - 1) begin
         exp_data = QUANT'((1 << (QUANT - 1)) - 1);
         exp_sat  = 1'b1;
      end else begin
         exp_data = QUANT'(v);
         exp_sat  = 1'b0;
      end
`else
      exp_data = QUANT'(v);
      exp_sat  = 1'b0;
`endif
      exp_valid = 1'b1;
      windows++;
      $display("window %0d ones=%0d expect out_data=%0d out_sat=%0d",
               windows, c, $signed(exp_data), exp_sat);
   endtask

   task automatic cycle(input bit v, input bit b, input bit ordy, input bit clr);
      bit rdy;
      bit acc;
      int c;
      in_valid  = v;
      in_bit    = b;
      out_ready = ordy;
      clear     = clr;
      #1;
      rdy = !(win_q.size() == BITSTREAM - 1 && exp_valid && !ordy);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      acc = v && rdy && !clr;
      @(posedge clk);
      if (clr) win_q.delete();
      else if (acc) win_q.push_back(b);
      if (win_q.size() == BITSTREAM) begin
         c = 0;
         foreach (win_q[i]) c += int'(win_q[i]);
         win_q.delete();
         model_load(c);
      end else if (exp_valid && ordy) begin
         exp_valid = 1'b0;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_sat", 32'(out_sat), 32'(exp_sat));
   endtask

   // Build a shuffled window holding exactly k ones and send its first n bits, with random idles.
   task automatic send_window(input int k, input bit ordy, input int n);
      for (int i = 0; i < BITSTREAM; i++) win_bits[i] = (i < k);
      for (int i = BITSTREAM - 1; i > 0; i--) begin
         int j;
         bit t;
         j = int'($urandom_range(0, i));
         t = win_bits[i];
         win_bits[i] = win_bits[j];
         win_bits[j] = t;
      end
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'($urandom), ordy, 1'b0);
         cycle(1'b1, win_bits[i], ordy, 1'b0);
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b1;
      in_bit    = 1'b1;
      clear     = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      win_q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_sat   = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
      exp_valid = 1'b0; exp_data = '0; exp_sat = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Alternating 1/0 window, consumer always ready: single-cycle pulse with value 0.
      for (int i = 0; i < BITSTREAM; i++) cycle(1'b1, 1'(i % 2 == 0), 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Boundary counts: 0, 1, 48, full window.
      send_window(0, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      send_window(1, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      send_window(48, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      send_window(BITSTREAM, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: two windows with no consumer; stall at the last bit, then release.
      send_window(int'($urandom_range(0, BITSTREAM)), 1'b0, BITSTREAM);
      send_window(int'($urandom_range(0, BITSTREAM)), 1'b0, BITSTREAM - 1);
      repeat (4) cycle(1'b1, win_bits[BITSTREAM-1], 1'b0, 1'b0);
      cycle(1'b1, win_bits[BITSTREAM-1], 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Clear mid-window drops the bit presented with it; next 64 ones decode alone.
      send_window(int'($urandom_range(0, 20)), 1'b1, 20);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      send_window(BITSTREAM, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset mid-window, then reset with a result pending, then a clean window.
      send_window(int'($urandom_range(0, BITSTREAM)), 1'b1, 30);
      do_reset();
      send_window(int'($urandom_range(0, BITSTREAM)), 1'b0, BITSTREAM);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      send_window(48, 1'b1, BITSTREAM);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic with occasional clears and intermittent consumer.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 99) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts a unipolar stochastic bitstream back into a signed QUANT-bit value. It counts the ones in each window of BITSTREAM accepted bits and rescales the count into the signed range. This is the inverse of the quota encoder: that block maps data to the number of ones in a BITSTREAM-length stream. The decoder sits at the output of the stochastic compute array, ahead of the quantized accumulation / writeback path.

## Interface
- BITSTREAM, 64, window length in bits; must be a power of two (elaboration-time error otherwise)
- QUANT, 8, output width; must satisfy QUANT >= $clog2(BITSTREAM) (elaboration-time error otherwise); SHIFT = QUANT - $clog2(BITSTREAM)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  abort current window (synchronous); pending output unaffected
- in_valid  input  1  in_bit is valid this cycle
- in_bit  input  1  stochastic bit
- in_ready  output  1  decoder accepts in_bit this cycle (combinational)
- out_valid  output  1  out_data holds a decoded value
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  QUANT  signed decoded value
- out_sat  output  1  out_data was saturated (see Configuration)

## Operation
- Bit accepted when in_valid && in_ready && !clear.
- State:
  - pos, $clog2(BITSTREAM) bits: index of the next bit in the window.
  - ones, $clog2(BITSTREAM)+1 bits: running count of ones.
  - One output register: out_data, out_sat, out_valid.
- On accept:
  - ones += in_bit; pos += 1.
  - If pos == BITSTREAM-1, the window completes:
    - Final count C = ones + in_bit, range 0..BITSTREAM.
    - Load the output register: out_valid=1, out_data = (C << SHIFT) - 2^(QUANT-1), computed in QUANT+1 bits.
    - Reset pos=0 and ones=0 in the same edge.
- Range of results:
  - C = 0 gives -2^(QUANT-1).
  - C = BITSTREAM/2 gives 0.
  - C = BITSTREAM gives the out-of-range value +2^(QUANT-1), handled per Configuration.
- Output handshake: out_valid && out_ready clears out_valid, unless a new window completes in the same cycle, in which case the new value loads and out_valid stays 1.
- in_ready = !(pos == BITSTREAM-1 && out_valid && !out_ready).
  - Input stalls only when the window is about to complete and the previous result is still unconsumed.
  - out_valid, out_data and out_sat never change while out_valid && !out_ready.
- clear:
  - Sets pos=0 and ones=0.
  - Any bit presented that cycle is dropped, even if in_valid=1.
  - clear has priority over window completion.
- rst sets pos=0, ones=0, out_valid=0, out_data=0 and out_sat=0. It overrides clear and all handshakes, including mid-window and while an output is pending.

## Timing
- Latency: out_valid rises on the edge that accepts the BITSTREAM-th bit. The value is visible the cycle after that bit was presented.
- Throughput: one bit per cycle sustained. Back-to-back windows incur no bubble provided out_ready is high on each completion cycle.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid or in_bit to any output.
- After rst deasserts: in_ready=1 and out_valid=0 in the first cycle.

## Configuration
- BSDEC_SAT_EN defined:
  - C = BITSTREAM yields out_data = 2^(QUANT-1)-1 and out_sat=1.
  - All other counts give out_sat=0.
- BSDEC_SAT_EN undefined:
  - out_data is the low QUANT bits of the result, so C = BITSTREAM wraps to -2^(QUANT-1).
  - out_sat is tied to 0.

## Test plan
All scenarios use defaults: BITSTREAM=64, QUANT=8, SHIFT=2.
- Reset, then 64 bits alternating 1/0 with in_valid=1 and out_ready=1 -> out_valid pulses for 1 cycle after the 64th bit, out_data=0.
- Window of 0 ones -> out_data=-128. Window with exactly 1 one -> -124. Window with 48 ones -> 64.
- Window of 64 ones -> with BSDEC_SAT_EN, out_data=127 and out_sat=1. Without it, out_data=-128 and out_sat=0.
- Two consecutive windows with out_ready=0 -> in_ready drops at pos=63 of the second window, first result holds stable. Raising out_ready -> first value consumed the same cycle the second loads, no bit lost.
- 20 bits, then clear with in_valid=1, then 64 bits of ones -> the bit under clear is dropped and the result reflects only the last 64 bits (127 with BSDEC_SAT_EN).
- rst asserted mid-window and again while out_valid=1 with out_ready=0 -> all outputs 0 next cycle. The next window decodes from pos=0.
